game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Game-flow controller for the crossy-road VGA game.
- Consumes the scroll position produced by the scroll unit and the collision flag from the sprite/car logic.
- Drives the scroll unit's control side: halt, speed_change (difficulty level) and game_rst.
- Tracks score as lanes crossed and sequences the IDLE → PLAY → DYING → OVER game states.

Parameters:
- LANE_H, 64, lane height in pixels; must be a power of two in the range 8..256.
- LEVEL_STEP, 8, number of lanes crossed per difficulty level increment.
- MAX_LEVEL, 200, saturation value of speed_change.
- DEATH_FRAMES, 60, number of frame_tick pulses spent frozen in DYING before OVER.

Ports:
- clk  in  1  system clock, 25 MHz.
- sys_rst  in  1  asynchronous, active-low reset.
- start_btn  in  1  debounced start button, level; rising edge detected internally.
- collision  in  1  level; high while the player overlaps a car.
- frame_tick  in  1  one-cycle pulse once per VGA frame.
- pos  in  11  scroll position from the scroll unit.
- halt  out  1  freezes scrolling when high.
- speed_change  out  8  difficulty level fed to the scroll unit.
- game_rst  out  1  one-cycle pulse that restarts the scroll unit.
- score  out  10  lanes crossed in the current game; saturates at 1023.
- state  out  3  current state: IDLE=0, ARM=1, PLAY=2, DYING=3, OVER=4.

Behaviour:
- Clock and reset
  - Single clock domain; all outputs are registered.
  - sys_rst low, asynchronously: state=IDLE, halt=1, speed_change=0, game_rst=0, score=0, last_lane=0, lane_cnt=0, death_cnt=0, start_q=0.
- Start edge detection
  - start_q registers start_btn; start_edge = start_btn & ~start_q.
  - A button held through reset release produces no edge.
- Lane index
  - cur_lane = pos >> log2(LANE_H), width LW = 11 − log2(LANE_H).
  - Lane arithmetic is modulo 2^LW. A forward step is cur_lane == last_lane+1 (mod 2^LW), so the 2047→0 wrap counts as a forward step.
- IDLE
  - halt=1.
  - start_edge → game_rst=1 next cycle, score=0, speed_change=0, lane_cnt=0; go to ARM.
- ARM (exactly one cycle)
  - game_rst returns to 0; halt=1.
  - last_lane ← cur_lane, sampled after the scroll unit has reset.
  - Go to PLAY.
- PLAY
  - halt=0.
  - collision=1: go to DYING; halt=1 from the next cycle. No score update in that cycle (collision wins over scoring).
  - Otherwise, on a forward step:
    - score ← min(score+1, 1023); last_lane ← cur_lane; lane_cnt+1.
    - When lane_cnt reaches LEVEL_STEP: lane_cnt ← 0 and speed_change ← min(speed_change+1, MAX_LEVEL).
  - Any other cur_lane ≠ last_lane (backward step or jump): last_lane ← cur_lane, no score.
  - start_edge is ignored.
- DYING
  - halt=1; score and speed_change are held.
  - death_cnt increments on each frame_tick; on the DEATH_FRAMES-th tick, death_cnt ← 0 and go to OVER.
  - start_edge and collision are ignored.
- OVER
  - halt=1; score is held for display.
  - start_edge behaves as in IDLE: game_rst pulse, clear score and level, go to ARM.
- Boundaries and invariants
  - game_rst is never high for more than one cycle.
  - A frame_tick in the same cycle as the DYING entry is not counted.
  - The score counter stops at 1023; the level stops at MAX_LEVEL and lane_cnt keeps cycling.
  - Unused state encodings go to IDLE.

Test Plan:
- Reset then release with start_btn held high → state stays IDLE, game_rst never asserted; drop start_btn and raise it → game_rst high for exactly 1 cycle, state ARM for 1 cycle, then PLAY with halt=0.
- In PLAY, step pos 0→64→128→…→64*8 (LANE_H=64) → score=8, speed_change=1 after the 8th step; step pos by 10 pixels within a lane → no score change.
- pos stepped 1984→2047→0 (lane 31→0) → counted as a forward step, score+1; pos stepped back 128→64 → score unchanged, last_lane=1.
- collision=1 on the same cycle as a lane crossing → score unchanged, state DYING next cycle, halt=1; 59 frame_ticks → still DYING; 60th → OVER; score held; start_btn edge during DYING → ignored.
- In OVER with score=37, start_btn edge → game_rst pulse, score=0, speed_change=0, back to PLAY two cycles later.
- Force 1100 lane crossings with MAX_LEVEL=5, LEVEL_STEP=2 → score=1023 saturated, speed_change=5 saturated; async sys_rst low mid-PLAY → all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller for the crossy-road VGA game: sequences IDLE/ARM/PLAY/DYING/OVER,
// counts lanes crossed as score and raises the difficulty level fed to the scroll unit.
module game_ctrl #(
    parameter int LANE_H       = 64,
    parameter int LEVEL_STEP   = 8,
    parameter int MAX_LEVEL    = 200,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        start_btn,
    input  logic        collision,
    input  logic        frame_tick,
    input  logic [10:0] pos,
    output logic        halt,
    output logic [7:0]  speed_change,
    output logic        game_rst,
    output logic [9:0]  score,
    output logic [2:0]  state
);

    localparam int LSH = $clog2(LANE_H);
    localparam int LW  = 11 - LSH;
    localparam int LCW = $clog2(LEVEL_STEP + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);

    localparam logic [LCW-1:0] LANE_STEP_C = LCW'(LEVEL_STEP);
    localparam logic [DCW-1:0] DEATH_LAST_C = DCW'(DEATH_FRAMES - 1);
    localparam logic [7:0]     MAX_LVL_C   = 8'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic           halt_q, halt_d;
    logic [7:0]     speed_q, speed_d;
    logic           game_rst_q, game_rst_d;
    logic [9:0]     score_q, score_d;
    logic [LW-1:0]  last_lane_q, last_lane_d;
    logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
    logic [DCW-1:0] death_cnt_q, death_cnt_d;
    logic           start_q;
    logic           armed_q;

    logic           start_edge_s;
    logic [LW-1:0]  cur_lane_s;
    logic [LW-1:0]  next_lane_s;
    logic [LCW-1:0] lane_cnt_inc_s;

    function automatic logic [9:0] sat_inc_score(input logic [9:0] s);
        return (s == 10'd1023) ? s : s + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc_level(input logic [7:0] l);
        return (l >= MAX_LVL_C) ? l : l + 8'd1;
    endfunction

    // armed_q masks the first cycle after reset so a button held through reset gives no edge
    assign start_edge_s   = start_btn & ~start_q & armed_q;
    assign cur_lane_s     = LW'(pos >> LSH);
    assign next_lane_s    = last_lane_q + LW'(1);
    assign lane_cnt_inc_s = lane_cnt_q + LCW'(1);

    // Next-state and datapath update for the game-flow FSM
    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        game_rst_d  = 1'b0;
        score_d     = score_q;
        last_lane_d = last_lane_q;
        lane_cnt_d  = lane_cnt_q;
        death_cnt_d = death_cnt_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge_s) begin
                    state_d    = S_ARM;
                    game_rst_d = 1'b1;
                    score_d    = 10'd0;
                    speed_d    = 8'd0;
                    lane_cnt_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ARM: begin
                last_lane_d = cur_lane_s;
                state_d     = S_PLAY;
            end
            S_PLAY: begin
                if (collision) begin
                    state_d     = S_DYING;
                    death_cnt_d = '0;
                end else if (cur_lane_s == next_lane_s) begin
                    score_d     = sat_inc_score(score_q);
                    last_lane_d = cur_lane_s;
                    if (lane_cnt_inc_s == LANE_STEP_C) begin
                        lane_cnt_d = '0;
                        speed_d    = sat_inc_level(speed_q);
                    end else begin
                        lane_cnt_d = lane_cnt_inc_s;
                    end
                end else if (cur_lane_s != last_lane_q) begin
                    last_lane_d = cur_lane_s;
                end else begin
                    last_lane_d = last_lane_q;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (death_cnt_q == DEATH_LAST_C) begin
                        death_cnt_d = '0;
                        state_d     = S_OVER;
                    end else begin
                        death_cnt_d = death_cnt_q + DCW'(1);
                    end
                end else begin
                    death_cnt_d = death_cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        halt_d = (state_d != S_PLAY);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= S_IDLE;
            halt_q      <= 1'b1;
            speed_q     <= 8'd0;
            game_rst_q  <= 1'b0;
            score_q     <= 10'd0;
            last_lane_q <= '0;
            lane_cnt_q  <= '0;
            death_cnt_q <= '0;
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            speed_q     <= speed_d;
            game_rst_q  <= game_rst_d;
            score_q     <= score_d;
            last_lane_q <= last_lane_d;
            lane_cnt_q  <= lane_cnt_d;
            death_cnt_q <= death_cnt_d;
            start_q     <= start_btn;
            armed_q     <= 1'b1;
        end
    end

    assign halt         = halt_q;
    assign speed_change = speed_q;
    assign game_rst     = game_rst_q;
    assign score        = score_q;
    assign state        = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed, table-driven bench for game_ctrl with a second instance at small level parameters.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        start_btn;
    logic        collision;
    logic        frame_tick;
    logic [10:0] pos;

    logic        halt_a, game_rst_a, halt_b, game_rst_b;
    logic [7:0]  speed_a, speed_b;
    logic [9:0]  score_a, score_b;
    logic [2:0]  state_a, state_b;

    int checks = 0;
    int errors = 0;

    game_ctrl dut_a (
        .clk(clk), .sys_rst(sys_rst), .start_btn(start_btn), .collision(collision),
        .frame_tick(frame_tick), .pos(pos), .halt(halt_a), .speed_change(speed_a),
        .game_rst(game_rst_a), .score(score_a), .state(state_a)
    );

    game_ctrl #(.LEVEL_STEP(2), .MAX_LEVEL(5)) dut_b (
        .clk(clk), .sys_rst(sys_rst), .start_btn(start_btn), .collision(collision),
        .frame_tick(frame_tick), .pos(pos), .halt(halt_b), .speed_change(speed_b),
        .game_rst(game_rst_b), .score(score_b), .state(state_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sb;
        logic        col;
        logic        ft;
        logic [10:0] p;
        logic [2:0]  st;
        logic        hl;
        logic [7:0]  spd;
        logic        gr;
        logic [9:0]  sc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input int st, input int hl, input int spd,
                         input int gr, input int sc);
        chk({nm, " state"}, int'(state_a), st);
        chk({nm, " halt"}, int'(halt_a), hl);
        chk({nm, " speed"}, int'(speed_a), spd);
        chk({nm, " game_rst"}, int'(game_rst_a), gr);
        chk({nm, " score"}, int'(score_a), sc);
    endtask

    task automatic step(input logic sb, input logic col, input logic ft, input logic [10:0] p);
        start_btn  = sb;
        collision  = col;
        frame_tick = ft;
        pos        = p;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sb, input logic col, input logic ft, input int p,
                       input int st, input int hl, input int spd, input int gr, input int sc);
        vec_t v;
        v.sb = sb; v.col = col; v.ft = ft; v.p = 11'(p);
        v.st = 3'(st); v.hl = 1'(hl); v.spd = 8'(spd); v.gr = 1'(gr); v.sc = 10'(sc);
        tbl.push_back(v);
    endtask

    initial begin
        // Held start across reset, then a real edge, then eight lane crossings
        add(1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0);
        add(1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0);
        add(1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0);
        add(1'b1, 1'b0, 1'b0, 0, 1, 1, 0, 1, 0);
        add(1'b1, 1'b0, 1'b0, 0, 2, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 1'b0, 64 * k, 2, 0, (k == 8) ? 1 : 0, 0, k);
        add(1'b1, 1'b0, 1'b0, 522, 2, 0, 1, 0, 8);
        add(1'b1, 1'b0, 1'b0, 532, 2, 0, 1, 0, 8);
        add(1'b1, 1'b0, 1'b0, 1984, 2, 0, 1, 0, 8);
        add(1'b1, 1'b0, 1'b0, 2047, 2, 0, 1, 0, 8);
        add(1'b1, 1'b0, 1'b0, 0, 2, 0, 1, 0, 9);
        add(1'b1, 1'b0, 1'b0, 64, 2, 0, 1, 0, 10);
        add(1'b1, 1'b0, 1'b0, 128, 2, 0, 1, 0, 11);
        add(1'b1, 1'b0, 1'b0, 64, 2, 0, 1, 0, 11);
        add(1'b1, 1'b0, 1'b0, 128, 2, 0, 1, 0, 12);
        add(1'b1, 1'b1, 1'b1, 192, 3, 1, 1, 0, 12);

        sys_rst = 1'b0; start_btn = 1'b1; collision = 1'b0; frame_tick = 1'b0; pos = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_a("reset", 0, 1, 0, 0, 0);
        sys_rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].sb, tbl[i].col, tbl[i].ft, tbl[i].p);
            chk_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].hl, tbl[i].spd, tbl[i].gr, tbl[i].sc);
        end

        // DYING ignores start and collision; counts 60 frame ticks
        step(1'b0, 1'b1, 1'b0, 11'd256);
        step(1'b1, 1'b1, 1'b0, 11'd320);
        chk_a("dying start ignored", 3, 1, 1, 0, 12);
        for (int i = 0; i < 59; i++) begin
            step(1'b1, 1'b0, 1'b1, 11'd0);
            step(1'b1, 1'b0, 1'b0, 11'd0);
        end
        chk_a("after 59 ticks", 3, 1, 1, 0, 12);
        step(1'b1, 1'b0, 1'b1, 11'd0);
        chk_a("60th tick", 4, 1, 1, 0, 12);

        // Restart from OVER
        step(1'b0, 1'b0, 1'b0, 11'd0);
        chk_a("over hold", 4, 1, 1, 0, 12);
        step(1'b1, 1'b0, 1'b0, 11'd0);
        chk_a("over restart", 1, 1, 0, 1, 0);
        step(1'b1, 1'b0, 1'b0, 11'd0);
        chk_a("replay", 2, 0, 0, 0, 0);

        // 1100 forward crossings saturate score and (instance b) level
        for (int k = 1; k <= 1100; k++) step(1'b1, 1'b0, 1'b0, 11'((64 * k) % 2048));
        chk("sat score a", int'(score_a), 1023);
        chk("sat speed a", int'(speed_a), 137);
        chk("sat score b", int'(score_b), 1023);
        chk("sat speed b", int'(speed_b), 5);
        chk("sat state b", int'(state_b), 2);

        // Asynchronous reset mid-PLAY, observed before any clock edge
        #1;
        sys_rst = 1'b0;
        #1;
        chk_a("async rst", 0, 1, 0, 0, 0);
        chk("async rst score b", int'(score_b), 0);
        chk("async rst speed b", int'(speed_b), 0);
        chk("async rst halt b", int'(halt_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
